// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction prefetch with credit-limited requests, prefetch FIFO and redirect flush
module fetch_unit #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [ADDR_WIDTH-1:0]        imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_addr,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0]        instr_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    typedef enum logic {FETCH, DRAIN} state_t;
    state_t r_state, w_state_next;

    logic [ADDR_WIDTH-1:0]        r_pc, r_pc_tag;
    logic [PW-1:0]                r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]                r_count, r_out, r_drop, w_out_next, w_drop_next;
    logic                         w_req_fire, w_push, w_pop, w_drop;
    logic [INSTRUCTION_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]        r_mem_pc [FIFO_DEPTH];

    // queued words plus in-flight requests never exceed the FIFO, so pushes cannot overflow
    assign imem_req_valid = !reset && r_state == FETCH && ({1'b0, r_count} + {1'b0, r_out}) < DEPTH_W;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = r_state == FETCH && r_count != '0;
    assign instruction    = instr_valid ? r_mem_data[r_rd_ptr] : '0;
    assign instr_pc       = instr_valid ? r_mem_pc[r_rd_ptr] : '0;

    assign w_req_fire = imem_req_valid & imem_req_ready;
    assign w_pop      = instr_valid & instr_ready;
    assign w_drop     = imem_rsp_valid & (redirect_valid | r_drop != '0);
    assign w_push     = imem_rsp_valid & ~w_drop;
    assign w_out_next = r_out + CW'(w_req_fire) - CW'(imem_rsp_valid);

    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        if (redirect_valid) begin
            w_drop_next  = w_out_next;
            w_state_next = (w_out_next != '0) ? DRAIN : FETCH;
        end else begin
            if (imem_rsp_valid && r_drop != '0) w_drop_next = r_drop - CW'(1);
            if (r_state == DRAIN && w_drop_next == '0) w_state_next = FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_pc_tag <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out    <= '0;
            r_drop   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_out    <= w_out_next;
            r_drop   <= w_drop_next;
            r_pc     <= redirect_valid ? redirect_addr : w_req_fire ? r_pc + ADDR_WIDTH'(1) : r_pc;
            r_pc_tag <= redirect_valid ? redirect_addr : w_push ? r_pc_tag + ADDR_WIDTH'(1) : r_pc_tag;
            r_wr_ptr <= redirect_valid ? '0 : r_wr_ptr + PW'(w_push);
            r_rd_ptr <= redirect_valid ? '0 : r_rd_ptr + PW'(w_pop);
            r_count  <= redirect_valid ? '0 : r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= imem_rsp_data;
            r_mem_pc[r_wr_ptr]   <= r_pc_tag;
        end
    end
endmodule
